// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALUOp encodings, R-type funct codes,
// multiply/divide state encoding and iteration length.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_SLT   = 2'b11
  } alu_op_e;

  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // Multiply/divide op select; equals funct[1:0] of mult/multu/div/divu.
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  localparam int         CALC_LEN  = 32;
  localparam logic [4:0] CALC_LAST = 5'(CALC_LEN - 1);

  // True for mult, multu, div, divu.
  function automatic logic is_md_op(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

  // True for every funct that touches HI/LO (and so must wait for the unit).
  function automatic logic uses_hilo(input logic [5:0] f);
    return is_md_op(f) || (f == F_MFHI) || (f == F_MFLO);
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per CALC cycle, sign correction in FIX, HI/LO written when FIX ends.
module ex_muldiv
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state;
  logic [4:0]  count;
  logic        is_div;
  logic        neg_a;
  logic        neg_b;
  logic        b_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;

  // Operand magnitudes for the issuing op (signed ops strip the sign).
  logic        in_signed;
  logic        in_neg_a;
  logic        in_neg_b;
  logic [31:0] in_mag_a;
  logic [31:0] in_mag_b;

  assign in_signed = ~op[0];
  assign in_neg_a  = in_signed & a[31];
  assign in_neg_b  = in_signed & b[31];
  assign in_mag_a  = in_neg_a ? (~a + 32'd1) : a;
  assign in_mag_b  = in_neg_b ? (~b + 32'd1) : b;

  assign busy = (state != MD_IDLE);

  // One iteration step and the final sign-corrected results.
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  logic        div_ge;
  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic [63:0] prod;
  logic [63:0] prod_fix;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  // Datapath for one CALC iteration and for the FIX correction.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : 33'd0);
    div_shift = {acc_hi, acc_lo[31]};
    div_trial = div_shift - {1'b0, mag_b};
    div_ge    = (div_shift >= {1'b0, mag_b});
    if (is_div) begin
      step_hi = div_ge ? div_trial[31:0] : div_shift[31:0];
      step_lo = {acc_lo[30:0], div_ge};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo[31:1]};
    end

    prod     = {acc_hi, acc_lo};
    prod_fix = (neg_a ^ neg_b) ? (~prod + 64'd1) : prod;
    if (!is_div) begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end else if (b_zero) begin
      // Divide by zero: all-ones quotient, dividend passed through as remainder.
      fix_hi = neg_a ? (~mag_a + 32'd1) : mag_a;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      fix_hi = neg_a ? (~acc_hi + 32'd1) : acc_hi;
      fix_lo = (neg_a ^ neg_b) ? (~acc_lo + 32'd1) : acc_lo;
    end
  end

  // Sequencer IDLE -> CALC (32 cycles) -> FIX -> IDLE with registered HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MD_IDLE;
      count  <= 5'd0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state  <= MD_CALC;
            count  <= 5'd0;
            is_div <= op[1];
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            b_zero <= (b == 32'd0);
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            acc_hi <= 32'd0;
            // Multiply shifts the multiplier out of acc_lo; divide shifts the dividend.
            acc_lo <= op[1] ? in_mag_a : in_mag_b;
          end
        end
        MD_CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (count == CALC_LAST) begin
            state <= MD_FIX;
            count <= 5'd0;
          end else begin
            count <= count + 5'd1;
          end
        end
        MD_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_muldiv.sv
// Execute stage: combinational ALU with operand/destination muxing, branch
// target adder and HI/LO access. The iterative multiply/divide unit and its
// stall logic are present only when EX_STAGE_MULDIV_EN is defined.
module ex_stage_muldiv
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:2] PC_4,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic [31:0] extended_offset,
  input  logic [20:16] WriteChoice1,
  input  logic [15:11] WriteChoice2,
  input  logic        RegDst,
  input  logic        ALUSrc,
  input  logic [1:0]  ALUOp,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteReg,
  output logic [31:2] BranchTarget,
  output logic        ex_stall,
  output logic        md_busy
);

  logic [5:0]  funct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] hi;
  logic [31:0] lo;

  assign funct        = extended_offset[5:0];
  assign op_a         = ReadData1;
  assign op_b         = ALUSrc ? extended_offset : ReadData2;
  assign WriteData    = ReadData2;
  assign WriteReg     = RegDst ? WriteChoice2 : WriteChoice1;
  assign BranchTarget = PC_4 + extended_offset[29:0];
  assign Zero         = (ALUResult == 32'd0);

`ifdef EX_STAGE_MULDIV_EN
  logic md_start;

  // Only an R-type mult/div starts the unit, and only when it is idle.
  assign md_start = ex_valid && (ALUOp == ALU_RTYPE) && is_md_op(funct) && !md_busy;

  // Any HI/LO user waits while the unit is running; the issuing op sees an idle unit.
  assign ex_stall = ex_valid && md_busy && uses_hilo(funct);

  ex_muldiv u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (funct[1:0]),
    .a     (op_a),
    .b     (op_b),
    .busy  (md_busy),
    .hi    (hi),
    .lo    (lo)
  );
`else
  logic unused_md;

  assign unused_md = ^{clk, rst, ex_valid};
  assign ex_stall  = 1'b0;
  assign md_busy   = 1'b0;
  assign hi        = 32'd0;
  assign lo        = 32'd0;
`endif

  // ALU result selection; overflow never traps, unknown funct yields 0.
  always_comb begin
    ALUResult = 32'd0;
    case (ALUOp)
      ALU_ADD: ALUResult = op_a + op_b;
      ALU_SUB: ALUResult = op_a - op_b;
      ALU_SLT: ALUResult = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: ALUResult = op_a + op_b;
          F_SUB, F_SUBU: ALUResult = op_a - op_b;
          F_AND:         ALUResult = op_a & op_b;
          F_OR:          ALUResult = op_a | op_b;
          F_XOR:         ALUResult = op_a ^ op_b;
          F_NOR:         ALUResult = ~(op_a | op_b);
          F_SLT:         ALUResult = {31'd0, $signed(op_a) < $signed(op_b)};
          F_SLTU:        ALUResult = {31'd0, op_a < op_b};
          F_MFHI:        ALUResult = hi;
          F_MFLO:        ALUResult = lo;
          default:       ALUResult = 32'd0;
        endcase
      end
      default: ALUResult = 32'd0;
    endcase
  end

endmodule

// File: doc/ex_stage_muldiv.md
EX_STAGE_MULDIV -- requirements
Module: ex_stage_muldiv

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port ex_valid, input, 1: a valid instruction occupies EX this cycle.
REQ-004 SHALL have ports PC_4 in [31:2], ReadData1 in 32, ReadData2 in 32 and extended_offset in 32; funct is taken from extended_offset[5:0].
REQ-005 SHALL have ports WriteChoice1 in [20:16], WriteChoice2 in [15:11], RegDst in 1 and ALUSrc in 1.
REQ-006 SHALL have port ALUOp, input, 2: 00 add, 01 sub, 10 R-type via funct, 11 slt.
REQ-007 SHALL have port ALUResult, output, 32: result of the ALU, mfhi or mflo.
REQ-008 SHALL have port Zero, output, 1: ALUResult equals 0.
REQ-009 SHALL have ports WriteData out 32 (= ReadData2), WriteReg out 5 and BranchTarget out [31:2].
REQ-010 SHALL have port ex_stall, output, 1: hold IF/ID and ID/EX and inject a bubble into EX/MEM.
REQ-011 SHALL have port md_busy, output, 1: multiply/divide unit not idle.

Function
REQ-012 SHALL drive operand B as extended_offset when ALUSrc=1, otherwise ReadData2.
REQ-013 SHALL drive WriteReg as WriteChoice2 when RegDst=1, otherwise WriteChoice1.
REQ-014 SHALL compute BranchTarget = PC_4 + extended_offset[29:0], modulo 2^30.
REQ-015 SHALL implement R-type funct codes 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 2B sltu, 10 mfhi, 12 mflo, 18 mult, 19 multu, 1A div, 1B divu (hex).
REQ-016 SHALL not trap on overflow; any undefined funct gives ALUResult 0.
REQ-017 SHALL make ALUResult, Zero, WriteData, WriteReg and BranchTarget combinational, with zero-cycle latency.
REQ-018 SHALL implement the muldiv state machine IDLE -> CALC (32 cycles, counter 0..31) -> FIX (1 cycle) -> IDLE.
REQ-019 SHALL start CALC when mult/multu/div/divu arrives with ex_valid=1, state IDLE and rst=0, and latch operand magnitudes plus sign flags.
REQ-020 SHALL use shift-add multiply and restoring divide, one bit per CALC cycle.
REQ-021 SHALL apply sign correction in FIX and write HI/LO at the end of FIX, exactly 33 edges after the issue edge.
REQ-022 SHALL ensure the issuing mult/div itself never stalls.
REQ-023 SHALL assert ex_stall while ex_valid=1, state is not IDLE and funct is 10, 12, 18, 19, 1A or 1B.
REQ-024 SHALL deassert ex_stall in the cycle after FIX; mfhi/mflo then read the new HI/LO.
REQ-025 SHALL, on divide by zero, set LO=FFFFFFFF and HI=dividend, with no stall beyond normal latency.
REQ-026 SHALL, for signed div, give quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a).
REQ-027 SHALL, for div 80000000/FFFFFFFF, give LO=80000000 and HI=0.
REQ-028 SHALL assert md_busy exactly when state is not IDLE.
REQ-029 SHALL, when ex_valid=0, ignore funct and keep ex_stall=0.

Reset
REQ-030 SHALL, while rst=1 (asynchronous), force state IDLE, counter 0, HI=0, LO=0 and clear operand/sign registers.
REQ-031 SHALL abort an in-flight operation on reset mid-CALC/FIX with no HI/LO update; md_busy=0 and ex_stall=0 immediately.
REQ-032 SHALL ignore a mult/div issued in the same cycle that rst deasserts only if rst is sampled high at that edge.

Configuration
REQ-033 SHALL, with macro EX_STAGE_MULDIV_EN defined, include the muldiv unit, HI/LO and stall logic.
REQ-034 SHALL, without EX_STAGE_MULDIV_EN, treat funct 18-1B as no-ops, make mfhi/mflo return 0, and tie ex_stall and md_busy to 0.

Structure
REQ-035 SHALL place the ALUOp encodings, funct constants, muldiv state encoding and the CALC length (32) in shared package pipeline_pkg.
REQ-036 SHALL implement the iterative unit as sub-module ex_muldiv (ports: clk, rst, start, op[1:0], a, b, busy, hi, lo); ALU muxing stays in ex_stage_muldiv.

Verification
REQ-037 SHALL cover: ALUOp=10, funct=20, ReadData1=7FFFFFFF, B=1 -> ALUResult=80000000, Zero=0, no stall.
REQ-038 SHALL cover: mult FFFFFFFE x 3, then mflo next cycle -> ex_stall high 33 cycles, then ALUResult=FFFFFFFA, mfhi=FFFFFFFF.
REQ-039 SHALL cover: divu 64 by 0 -> after 33 cycles LO=FFFFFFFF, HI=64.
REQ-040 SHALL cover: div FFFFFFF9 (-7) by 2 -> LO=FFFFFFFD, HI=FFFFFFFF.
REQ-041 SHALL cover: rst pulsed at CALC count 10 -> md_busy=0 at once, mfhi=0, and a following multu 5x5 gives LO=19.
REQ-042 SHALL cover: build without EX_STAGE_MULDIV_EN, mult then mflo -> ALUResult=0, ex_stall never asserts.
